// File: rtl/bp_fb_sched.sv
// bp_fb_sched: queues resolved branches from two sources and issues one BHT update per cycle.
// Optional issue/mispredict statistics are built when BP_FB_STAT_EN is defined.
`ifndef ADDR_TP
`define ADDR_TP logic [31:0]
`endif

module bp_fb_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        s0_vld,
  input  logic        s0_tk,
  input  logic        s0_mis,
  input  `ADDR_TP     s0_pc,
  input  logic        s1_vld,
  input  logic        s1_tk,
  input  logic        s1_mis,
  input  `ADDR_TP     s1_pc,
  output logic        s0_rdy,
  output logic        s1_rdy,
  input  logic        clr,
  output logic        fb_ena,
  output logic        fb_tk,
  output `ADDR_TP     fb_pc,
  output logic [31:0] upd_cnt,
  output logic [31:0] mis_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(32'd2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  `ADDR_TP        pc_mem_r [DEPTH];
  logic           tk_mem_r [DEPTH];
  logic [CW-1:0]  count_r;
  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [CW-1:0]  free_s;
  logic [CW-1:0]  count_nxt_s;
  logic [PW-1:0]  tail_nxt_s;
  logic [PW-1:0]  wr1_idx_s;
  logic           acc0_s;
  logic           acc1_s;
  logic           pop_s;

  // Credit is taken from the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    free_s      = CNT_FULL - count_r;
    s0_rdy      = (free_s >= CNT_ONE);
    s1_rdy      = (free_s >= CNT_TWO) || ((free_s == CNT_ONE) && !s0_vld);
    acc0_s      = rdy && !clr && s0_vld && s0_rdy;
    acc1_s      = rdy && !clr && s1_vld && s1_rdy;
    pop_s       = rdy && !clr && (count_r != {CW{1'b0}});
    wr1_idx_s   = tail_r + PW'(acc0_s);
    tail_nxt_s  = tail_r + PW'(acc0_s) + PW'(acc1_s);
    count_nxt_s = count_r + CW'(acc0_s) + CW'(acc1_s) - CW'(pop_s);
  end

  // Entry storage; s1 lands one slot after s0 when both are accepted together.
  always_ff @(posedge clk) begin
    if (acc0_s) begin
      pc_mem_r[tail_r] <= s0_pc;
      tk_mem_r[tail_r] <= s0_tk;
    end
    if (acc1_s) begin
      pc_mem_r[wr1_idx_s] <= s1_pc;
      tk_mem_r[wr1_idx_s] <= s1_tk;
    end
  end

  // Queue pointers and the registered update strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CW{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      fb_ena  <= 1'b0;
      fb_tk   <= 1'b0;
      fb_pc   <= {$bits(fb_pc){1'b0}};
    end else if (rdy) begin
      if (clr) begin
        count_r <= {CW{1'b0}};
        head_r  <= {PW{1'b0}};
        tail_r  <= {PW{1'b0}};
        fb_ena  <= 1'b0;
      end else begin
        count_r <= count_nxt_s;
        tail_r  <= tail_nxt_s;
        if (pop_s) begin
          head_r <= head_r + PW'(1'b1);
          fb_ena <= 1'b1;
          fb_pc  <= pc_mem_r[head_r];
          fb_tk  <= tk_mem_r[head_r];
        end else begin
          fb_ena <= 1'b0;
        end
      end
    end else begin
      fb_ena <= 1'b0;
    end
  end

`ifdef BP_FB_STAT_EN
  logic           mis_mem_r [DEPTH];
  logic [31:0]    upd_cnt_r;
  logic [31:0]    mis_cnt_r;

  // Mispredict flag storage alongside each entry.
  always_ff @(posedge clk) begin
    if (acc0_s) begin
      mis_mem_r[tail_r] <= s0_mis;
    end
    if (acc1_s) begin
      mis_mem_r[wr1_idx_s] <= s1_mis;
    end
  end

  // Statistics count issued updates and survive clr; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_cnt_r <= 32'd0;
      mis_cnt_r <= 32'd0;
    end else if (pop_s) begin
      upd_cnt_r <= upd_cnt_r + 32'd1;
      mis_cnt_r <= mis_cnt_r + {31'd0, mis_mem_r[head_r]};
    end else begin
      upd_cnt_r <= upd_cnt_r;
      mis_cnt_r <= mis_cnt_r;
    end
  end

  assign upd_cnt = upd_cnt_r;
  assign mis_cnt = mis_cnt_r;
`else
  logic unused_mis_s;
  assign unused_mis_s = s0_mis ^ s1_mis;
  assign upd_cnt      = 32'd0;
  assign mis_cnt      = 32'd0;
`endif

endmodule

// File: tb/tb_bp_fb_sched.sv
// Randomised scoreboard bench for bp_fb_sched against a queue-based reference model.
`ifndef ADDR_TP
`define ADDR_TP logic [31:0]
`endif

module tb_bp_fb_sched;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic        mis;
    int          cyc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0, clr = 1'b0;
  logic        s0_vld = 1'b0, s0_tk = 1'b0, s0_mis = 1'b0;
  logic        s1_vld = 1'b0, s1_tk = 1'b0, s1_mis = 1'b0;
  logic [31:0] s0_pc = '0, s1_pc = '0;
  logic        s0_rdy, s1_rdy, fb_ena, fb_tk;
  logic [31:0] fb_pc, upd_cnt, mis_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  ent_t        fifo_q[$];
  ent_t        sb_q[$];
  ent_t        mon_e;
  logic [31:0] m_upd = '0;
  logic [31:0] m_mis = '0;

  bp_fb_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .s0_vld(s0_vld), .s0_tk(s0_tk), .s0_mis(s0_mis), .s0_pc(s0_pc),
    .s1_vld(s1_vld), .s1_tk(s1_tk), .s1_mis(s1_mis), .s1_pc(s1_pc),
    .s0_rdy(s0_rdy), .s1_rdy(s1_rdy), .clr(clr),
    .fb_ena(fb_ena), .fb_tk(fb_tk), .fb_pc(fb_pc),
    .upd_cnt(upd_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: evaluated between edges for the coming rising edge.
  task automatic model_step();
    int   free;
    ent_t e;
    free = DEPTH - fifo_q.size();
    chk("s0_rdy", {31'd0, s0_rdy}, {31'd0, free >= 1});
    chk("s1_rdy", {31'd0, s1_rdy}, {31'd0, (free >= 2) || (free == 1 && !s0_vld)});
`ifdef BP_FB_STAT_EN
    chk("upd_cnt", upd_cnt, m_upd);
    chk("mis_cnt", mis_cnt, m_mis);
`else
    chk("upd_cnt", upd_cnt, 32'd0);
    chk("mis_cnt", mis_cnt, 32'd0);
`endif
    if (rdy && !clr && fifo_q.size() > 0) begin
      e = fifo_q.pop_front();
      e.cyc = cyc + 1;
      sb_q.push_back(e);
      m_upd = m_upd + 1;
      if (e.mis) m_mis = m_mis + 1;
    end
    if (rdy && clr) begin
      fifo_q.delete();
    end else if (rdy) begin
      if (s0_vld && free >= 1) begin
        e.pc = s0_pc; e.tk = s0_tk; e.mis = s0_mis; e.cyc = 0;
        fifo_q.push_back(e);
        free--;
      end
      if (s1_vld && free >= 1) begin
        e.pc = s1_pc; e.tk = s1_tk; e.mis = s1_mis; e.cyc = 0;
        fifo_q.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] p0, input logic t0, input logic m0,
                       input logic v1, input logic [31:0] p1, input logic t1, input logic m1,
                       input logic r, input logic c);
    s0_vld = v0; s0_pc = p0; s0_tk = t0; s0_mis = m0;
    s1_vld = v1; s1_pc = p1; s1_tk = t1; s1_mis = m1;
    rdy = r; clr = c;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: every fb_ena must match the oldest expected issue in its exact cycle.
  always @(negedge clk) begin
    if (rst) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL fb_missing actual=no_issue expected pc=%h at cycle %0d", sb_q[0].pc, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
      if (fb_ena) begin
        checks++;
        if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL fb_spurious actual=fb_ena pc=%h expected=no_issue (cycle %0d)", fb_pc, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          if (fb_pc !== mon_e.pc || fb_tk !== mon_e.tk) begin
            errors++;
            $display("FAIL fb_data actual=%h/%b expected=%h/%b (cycle %0d)", fb_pc, fb_tk, mon_e.pc, mon_e.tk, cyc);
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fb_ena", {31'd0, fb_ena}, 32'd0);
    chk("rst_fb_pc", fb_pc, 32'd0);
    chk("rst_upd_cnt", upd_cnt, 32'd0);
    rst = 1'b1;
    idle(2);

    // Single push latency and a dual push into an empty queue.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Back-pressure with both sources always valid.
    for (int i = 0; i < 6; i++)
      drive(1'b1, 32'h200 + i, 1'b1, 1'b0, 1'b1, 32'h300 + i, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);

    // Three entries queued, then clr, then six pushes to wrap the pointers.
    drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 32'h401, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h402, 1'b0, 1'b0, 1'b1, 32'h403, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    for (int i = 0; i < 6; i++)
      drive(1'b1, 32'h500 + i, i[0], 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Five updates, two of them mispredicted.
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'h600 + i, 1'b1, (i == 1 || i == 3), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Asynchronous reset between edges with two entries queued.
    drive(1'b1, 32'h700, 1'b1, 1'b0, 1'b1, 32'h701, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_fb_ena", {31'd0, fb_ena}, 32'd0);
    chk("arst_upd_cnt", upd_cnt, 32'd0);
    chk("arst_mis_cnt", mis_cnt, 32'd0);
    fifo_q.delete();
    sb_q.delete();
    m_upd = '0;
    m_mis = '0;
    s0_vld = 1'b0; s1_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(4);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0));
    idle(10);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
